// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor (slave) and the top level / PLL side (master).
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_lost;
  logic [7:0] relock_count;
  logic       fail;

  modport master (
    output pll_locked, force_relock,
    input  pll_rst, sys_rst_n, lock_lost, relock_count, fail
  );

  modport slave (
    input  pll_locked, force_relock,
    output pll_rst, sys_rst_n, lock_lost, relock_count, fail
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock monitor; releases sys_rst_n only after a stable lock period.
// Optional retry limit with a sticky FAIL state when PLL_SUP_RETRY_LIMIT_EN is defined.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 16,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_lock_supervisor_if.slave  io_pll
);

  localparam int MAX_CNT_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT   = (MAX_CNT_A > STABLE_CYCLES) ? MAX_CNT_A : STABLE_CYCLES;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (RST_CYCLES < 1 || MAX_RETRIES < 1 || CNT_W < $clog2(MAX_CNT)) begin : g_paramCheck
    $error("pll_lock_supervisor: invalid parameter combination");
  end

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;
`else
  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_timer;
  logic             r_lkMeta;
  logic             r_lk;
  logic             r_pllRst;
  logic             r_sysRstN;
  logic             r_lockLost;
  logic [7:0]       r_relockCount;
  logic             w_pllRst;
  logic             w_sysRstN;
  logic             w_lockLost;
  logic             w_enterReset;

`ifdef PLL_SUP_RETRY_LIMIT_EN
  logic [RW-1:0]    r_retryCount;
  logic             r_fail;
  logic             w_fail;
  logic             w_timeout;
`endif

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lkMeta <= 1'b0;
      r_lk     <= 1'b0;
    end else begin
      r_lkMeta <= io_pll.pll_locked;
      r_lk     <= r_lkMeta;
    end
  end

  always_comb begin
    w_nextState = r_state;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      RESET_PLL: begin
        if (r_timer == RST_LAST) w_nextState = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (io_pll.force_relock) begin
          w_nextState = RESET_PLL;
        end else if (r_lk) begin
          w_nextState = STABLE;
        end else if (r_timer == LOCK_LAST) begin
          w_nextState = RESET_PLL;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          w_timeout = 1'b1;
          if (r_retryCount == RETRY_LAST) w_nextState = FAIL;
`endif
        end
      end
      STABLE: begin
        if (io_pll.force_relock) begin
          w_nextState = RESET_PLL;
        end else if (!r_lk) begin
          w_nextState = WAIT_LOCK;
        end else if (r_timer == STABLE_LAST) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (io_pll.force_relock || !r_lk) w_nextState = RESET_PLL;
      end
`ifdef PLL_SUP_RETRY_LIMIT_EN
      FAIL: begin
        w_nextState = FAIL;
      end
`endif
      default: begin
        w_nextState = RESET_PLL;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    w_enterReset = (r_state != RESET_PLL) && (w_nextState == RESET_PLL);
    w_pllRst     = (w_nextState == RESET_PLL);
    w_sysRstN    = (w_nextState == RUN);
    w_lockLost   = (r_state == RUN) && !r_lk;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    w_fail       = (w_nextState == FAIL);
    if (w_fail) w_pllRst = 1'b1;
`endif
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_PLL;
      r_timer <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) r_timer <= '0;
      else                        r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pllRst      <= 1'b1;
      r_sysRstN     <= 1'b0;
      r_lockLost    <= 1'b0;
      r_relockCount <= 8'd0;
    end else begin
      r_pllRst   <= w_pllRst;
      r_sysRstN  <= w_sysRstN;
      r_lockLost <= w_lockLost;
      if (w_enterReset && (r_relockCount != 8'hFF)) r_relockCount <= r_relockCount + 8'd1;
    end
  end

`ifdef PLL_SUP_RETRY_LIMIT_EN
  // Retry count tracks consecutive timeouts; any successful lock into RUN forgives them
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_retryCount <= '0;
      r_fail       <= 1'b0;
    end else begin
      r_fail <= w_fail;
      if ((w_nextState == RUN) && (r_state != RUN)) r_retryCount <= '0;
      else if (w_timeout)                           r_retryCount <= r_retryCount + 1'b1;
    end
  end

  assign io_pll.fail = r_fail;
`else
  assign io_pll.fail = 1'b0;
`endif

  assign io_pll.pll_rst      = r_pllRst;
  assign io_pll.sys_rst_n    = r_sysRstN;
  assign io_pll.lock_lost    = r_lockLost;
  assign io_pll.relock_count = r_relockCount;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scoreboard bench for pll_lock_supervisor using small timing parameters.
// Honours PLL_SUP_RETRY_LIMIT_EN for the retry-limit scenario.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 16;
  localparam int SYNC_LAT      = 2;
  // Lock edge to sys_rst_n: synchroniser, the WAIT_LOCK->STABLE edge, then the stable window
  localparam int LOCK_TO_RUN   = SYNC_LAT + 1 + STABLE_CYCLES;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int NUM_TIMEOUTS  = MAX_RETRIES;
`else
  localparam int NUM_TIMEOUTS  = 3;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic refclk = 1'b0;
  logic rst_n;
  pll_lock_supervisor_if bus ();

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   expRelock   = 0;
  int   cycles;
  int   lateCount;
  int   rstSeen;
  int   sysSeen;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .io_pll (bus)
  );

  always #5 refclk = ~refclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
      return;
    end
    e = expQ.pop_front();
    assert (observed === e.val) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.val);
    end
  endtask

  task automatic expectNow(input string tag, input logic [31:0] expected, input logic [31:0] observed);
    pushExp(tag, expected);
    checkOutput(observed);
  endtask

  task automatic applyStimulus(input logic locked, input logic force_req);
    bus.pll_locked   = locked;
    bus.force_relock = force_req;
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return bus.pll_rst;
      1:       return bus.sys_rst_n;
      default: return bus.lock_lost;
    endcase
  endfunction

  // Counts edges until the selected output reaches val; -1 if the bound expires
  task automatic waitFor(input int sel, input logic val, input int maxCycles, output int count);
    count = 0;
    forever begin
      tick();
      count++;
      if (sigSel(sel) === val) break;
      if (count >= maxCycles) begin
        count = -1;
        break;
      end
    end
  endtask

  task automatic checkResetValues(input string prefix);
    expectNow({prefix, "_pll_rst"},      1, bus.pll_rst);
    expectNow({prefix, "_sys_rst_n"},    0, bus.sys_rst_n);
    expectNow({prefix, "_lock_lost"},    0, bus.lock_lost);
    expectNow({prefix, "_relock_count"}, 0, bus.relock_count);
    expectNow({prefix, "_fail"},         0, bus.fail);
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkResetValues("reset");
    tick();
    tick();

    // 1: power-up lock
    rst_n = 1'b1;
    pushExp("rst_pulse_width", RST_CYCLES);
    waitFor(0, 1'b0, 50, cycles);
    checkOutput(cycles);
    expectNow("fail_idle", 0, bus.fail);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 1'b0);
    pushExp("lock_to_run", LOCK_TO_RUN);
    waitFor(1, 1'b1, 100, cycles);
    checkOutput(cycles);
    expectNow("run_relock_count", 0, bus.relock_count);
    expectNow("run_pll_rst", 0, bus.pll_rst);
    expectNow("run_lock_lost", 0, bus.lock_lost);

    // 2: lock loss in RUN
    tick();
    tick();
    applyStimulus(1'b0, 1'b0);
    pushExp("lock_lost_latency", SYNC_LAT + 1);
    waitFor(2, 1'b1, 20, cycles);
    checkOutput(cycles);
    expRelock = 1;
    expectNow("loss_pll_rst", 1, bus.pll_rst);
    expectNow("loss_sys_rst_n", 0, bus.sys_rst_n);
    expectNow("loss_relock_count", expRelock, bus.relock_count);
    tick();
    expectNow("lock_lost_one_cycle", 0, bus.lock_lost);

    // 3: glitch during STABLE restarts the stable window without a PLL reset
    pushExp("relock_pulse_width", RST_CYCLES - 1);
    waitFor(0, 1'b0, 50, cycles);
    checkOutput(cycles);
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    tick();
    rstSeen = 0;
    sysSeen = 0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.pll_rst)   rstSeen++;
      if (bus.sys_rst_n) sysSeen++;
    end
    applyStimulus(1'b1, 1'b0);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.pll_rst) rstSeen++;
      if (bus.sys_rst_n) begin
        cycles = i;
        break;
      end
    end
    expectNow("glitch_sys_rst_n_low", 0, sysSeen);
    expectNow("glitch_no_pll_rst", 0, rstSeen);
    expectNow("glitch_restart_window", LOCK_TO_RUN, cycles);
    expectNow("glitch_relock_count", expRelock, bus.relock_count);

    // 4: no lock at all -> repeated timeouts
    applyStimulus(1'b0, 1'b0);
    pushExp("timeout_entry_latency", SYNC_LAT + 1);
    waitFor(2, 1'b1, 20, cycles);
    checkOutput(cycles);
    expRelock++;
    expectNow("timeout_entry_relock", expRelock, bus.relock_count);
    for (int t = 1; t <= NUM_TIMEOUTS; t++) begin
      pushExp($sformatf("to%0d_rst_high", t), RST_CYCLES);
      waitFor(0, 1'b0, 50, cycles);
      checkOutput(cycles);
      pushExp($sformatf("to%0d_wait_len", t), LOCK_TIMEOUT);
      waitFor(0, 1'b1, 50, cycles);
      checkOutput(cycles);
`ifdef PLL_SUP_RETRY_LIMIT_EN
      if (t == MAX_RETRIES) begin
        expectNow("fail_asserted", 1, bus.fail);
      end else begin
        expRelock++;
        expectNow($sformatf("to%0d_fail", t), 0, bus.fail);
      end
`else
      expRelock++;
      expectNow($sformatf("to%0d_fail", t), 0, bus.fail);
`endif
      expectNow($sformatf("to%0d_relock", t), expRelock, bus.relock_count);
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    rstSeen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!bus.pll_rst) rstSeen++;
    end
    expectNow("fail_pll_rst_held", 0, rstSeen);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    expectNow("fail_force_ignored_relock", expRelock, bus.relock_count);
    expectNow("fail_sticky", 1, bus.fail);
    expectNow("fail_sys_rst_n", 0, bus.sys_rst_n);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expRelock = 0;
`endif

    // 5: lock drop coinciding with force_relock, then saturation
    pushExp("bringup_rst_high", RST_CYCLES);
    waitFor(0, 1'b0, 60, cycles);
    checkOutput(cycles);
    applyStimulus(1'b1, 1'b0);
    pushExp("bringup_lock_to_run", LOCK_TO_RUN);
    waitFor(1, 1'b1, 100, cycles);
    checkOutput(cycles);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    expRelock++;
    expectNow("combo_lock_lost", 1, bus.lock_lost);
    expectNow("combo_relock_once", expRelock, bus.relock_count);
    expectNow("combo_pll_rst", 1, bus.pll_rst);
    tick();
    expectNow("combo_lock_lost_single", 0, bus.lock_lost);
    expectNow("combo_relock_stable", expRelock, bus.relock_count);

    lateCount = 0;
    for (int i = 0; i < 300; i++) begin
      waitFor(0, 1'b0, 20, cycles);
      if (cycles < 0) lateCount++;
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      if (expRelock < 255) expRelock++;
      if (i == 0) expectNow("force_first_increment", expRelock, bus.relock_count);
    end
    expectNow("force_loop_no_stall", 0, lateCount);
    expectNow("relock_saturated", 255, bus.relock_count);
    expectNow("relock_model_saturated", 255, expRelock);

    // 6: asynchronous reset in WAIT_LOCK
    waitFor(0, 1'b0, 20, cycles);
    tick();
    tick();
    tick();
    expectNow("prereset_pll_rst", 0, bus.pll_rst);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
